// File: rtl/gcbp_pkg.sv
// Shared types and widths for the GCBP bit-plane reader.
package gcbp_pkg;

    // Reader control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } gcbp_state_t;

    localparam int SLOT_W     = 2;    // frame-slot select
    localparam int WADDR_W    = 7;    // word index within a slot
    localparam int BADDR_W    = 9;    // full BRAM address {slot, word}
    localparam int DW_DEFAULT = 128;  // 16 lanes x 8 bits

    // BRAM address of one word in one frame slot.
    function automatic logic [BADDR_W-1:0] bram_addr(input logic [SLOT_W-1:0]  slot,
                                                     input logic [WADDR_W-1:0] word);
        return {slot, word};
    endfunction

endpackage

// File: rtl/gcbp_skid_fifo.sv
// Two-entry skid FIFO holding returned BRAM word pairs until the consumer
// accepts them.
module gcbp_skid_fifo
    import gcbp_pkg::*;
#(
    parameter int WIDTH = 2*DW_DEFAULT + WADDR_W
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a push when the head is leaving; a flush drops anything arriving.
    assign do_pop  = i_pop && (count != 2'd0) && !i_flush;
    assign do_push = i_push && !i_flush && ((count != 2'd2) || do_pop);

    // Pointer and occupancy tracking; flush empties the FIFO at once.
    always_ff @(posedge i_clk) begin
        if (!i_resetn || i_flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Entry storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    assign o_data  = mem[rd_ptr];
    assign o_empty = (count == 2'd0);
    assign o_count = count;

endmodule

// File: rtl/gcbp_reader.sv
// Streams one full frame of bit-plane words out of two BRAM ports (current
// and previous frame slots) as paired words over a valid/ready handshake.
module gcbp_reader
    import gcbp_pkg::*;
#(
    parameter int WORDS = 128,
    parameter int DW    = DW_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_resetn,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [SLOT_W-1:0]  i_curr_frame_loc,
    input  logic [SLOT_W-1:0]  i_prev_frame_loc,
    output logic [BADDR_W-1:0] o_bram_rd_addr_a,
    output logic [BADDR_W-1:0] o_bram_rd_addr_b,
    output logic               o_bram_rd_en,
    input  logic [DW-1:0]      i_bram_rd_data_a,
    input  logic [DW-1:0]      i_bram_rd_data_b,
    output logic [DW-1:0]      o_curr_data,
    output logic [DW-1:0]      o_prev_data,
    output logic [WADDR_W-1:0] o_word_idx,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_last,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_start_err
);

    localparam int                 FW       = 2*DW + WADDR_W;
    localparam logic [WADDR_W-1:0] LAST_IDX = WADDR_W'(WORDS - 1);

    gcbp_state_t        state;
    gcbp_state_t        state_nxt;
    logic [WADDR_W-1:0] rd_cnt;
    logic [SLOT_W-1:0]  curr_loc;
    logic [SLOT_W-1:0]  prev_loc;
    logic               rd_en;

    // Read issued last cycle; its data is on the BRAM outputs this cycle.
    logic               vld_p1;
    logic [WADDR_W-1:0] idx_p1;

    logic               fifo_push;
    logic [FW-1:0]      fifo_wdata;
    logic [FW-1:0]      fifo_head;
    logic               fifo_empty;
    logic [1:0]         fifo_count;
    logic [2:0]         occupancy;

    logic               xfer;
    logic               xfer_last;
    logic               start_ok;
    logic               done_q;
    logic               start_err_q;

    assign xfer      = o_valid && i_ready;
    assign xfer_last = xfer && o_last;
    assign start_ok  = i_start && (state == ST_IDLE) && !i_abort;

    // Slots committed for the next cycle: stored entries plus the read in
    // flight, minus the head leaving now. Counting the departing head keeps
    // one read per cycle when the consumer is always ready.
    assign occupancy = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, xfer};

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and read-strobe decode; abort overrides everything.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                rd_en = (occupancy < 3'd2);
                if (rd_en && (rd_cnt == LAST_IDX)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (i_abort) begin
            state_nxt = ST_IDLE;
            rd_en     = 1'b0;
        end
    end

    // Read counter, latched frame slots, in-flight tracking and status pulses.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            rd_cnt      <= '0;
            curr_loc    <= '0;
            prev_loc    <= '0;
            vld_p1      <= 1'b0;
            idx_p1      <= '0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                idx_p1 <= rd_cnt;
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (start_ok) begin
                curr_loc <= i_curr_frame_loc;
                prev_loc <= i_prev_frame_loc;
                rd_cnt   <= '0;
            end
            done_q      <= xfer_last && !i_abort;
            start_err_q <= i_start && (state != ST_IDLE) && !i_abort;
        end
    end

    // Returning data is captured with the index of the read that fetched it;
    // anything still in flight when an abort lands is dropped.
    assign fifo_push  = vld_p1 && !i_abort;
    assign fifo_wdata = {idx_p1, i_bram_rd_data_a, i_bram_rd_data_b};

    gcbp_skid_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_flush  (i_abort),
        .i_push   (fifo_push),
        .i_data   (fifo_wdata),
        .i_pop    (xfer),
        .o_data   (fifo_head),
        .o_empty  (fifo_empty),
        .o_count  (fifo_count)
    );

    assign o_bram_rd_addr_a = bram_addr(curr_loc, rd_cnt);
    assign o_bram_rd_addr_b = bram_addr(prev_loc, rd_cnt);
    assign o_bram_rd_en     = rd_en;

    assign o_valid     = !fifo_empty;
    assign o_word_idx  = fifo_head[FW-1 -: WADDR_W];
    assign o_curr_data = fifo_head[2*DW-1 -: DW];
    assign o_prev_data = fifo_head[DW-1:0];
    assign o_last      = o_valid && (o_word_idx == LAST_IDX);

    assign o_busy      = (state != ST_IDLE);
    assign o_done      = done_q;
    assign o_start_err = start_err_q;

endmodule

// File: tb/tb_gcbp_reader.sv
// Scoreboard bench for gcbp_reader: a BRAM model answers reads with
// address-derived patterns, expected word pairs are queued at each start and
// popped on every output transfer.
module tb_gcbp_reader;

    localparam int WORDS = 128;
    localparam int DW    = 128;
    localparam int EW    = 2*DW + 7;

    typedef logic [EW-1:0] vec_t;

    logic          i_clk = 1'b0;
    logic          i_resetn;
    logic          i_start;
    logic          i_abort;
    logic [1:0]    i_curr_frame_loc;
    logic [1:0]    i_prev_frame_loc;
    logic [8:0]    o_bram_rd_addr_a;
    logic [8:0]    o_bram_rd_addr_b;
    logic          o_bram_rd_en;
    logic [DW-1:0] i_bram_rd_data_a;
    logic [DW-1:0] i_bram_rd_data_b;
    logic [DW-1:0] o_curr_data;
    logic [DW-1:0] o_prev_data;
    logic [6:0]    o_word_idx;
    logic          o_valid;
    logic          i_ready;
    logic          o_last;
    logic          o_busy;
    logic          o_done;
    logic          o_start_err;

    always #5 i_clk = ~i_clk;

    gcbp_reader #(
        .WORDS (WORDS),
        .DW    (DW)
    ) dut (
        .i_clk            (i_clk),
        .i_resetn         (i_resetn),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_curr_frame_loc (i_curr_frame_loc),
        .i_prev_frame_loc (i_prev_frame_loc),
        .o_bram_rd_addr_a (o_bram_rd_addr_a),
        .o_bram_rd_addr_b (o_bram_rd_addr_b),
        .o_bram_rd_en     (o_bram_rd_en),
        .i_bram_rd_data_a (i_bram_rd_data_a),
        .i_bram_rd_data_b (i_bram_rd_data_b),
        .o_curr_data      (o_curr_data),
        .o_prev_data      (o_prev_data),
        .o_word_idx       (o_word_idx),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_last           (o_last),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_start_err      (o_start_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Distinct pattern per BRAM address and port.
    function automatic logic [DW-1:0] pat(input logic [8:0] a, input logic port);
        return {8{{port, 6'd0, a}}};
    endfunction

    // BRAM model: registered read, data valid the cycle after the strobe.
    always @(posedge i_clk) begin
        if (o_bram_rd_en) begin
            i_bram_rd_data_a <= pat(o_bram_rd_addr_a, 1'b0);
            i_bram_rd_data_b <= pat(o_bram_rd_addr_b, 1'b1);
        end
    end

    vec_t       sb[$];
    vec_t       held;
    vec_t       exp_e;
    bit         mon_en     = 1'b0;
    bit         stalled    = 1'b0;
    bit         last_fired = 1'b0;
    logic [1:0] cur_a      = 2'd0;
    logic [1:0] cur_b      = 2'd0;
    logic [6:0] rd_idx     = 7'd0;
    int         xfers      = 0;
    int         rd_pulses  = 0;

    // Monitor: sampled mid-cycle, ahead of the edge that completes transfers.
    always @(negedge i_clk) begin
        if (mon_en) begin
            chk("done_pulse", vec_t'(o_done), vec_t'(last_fired));
            if (stalled) begin
                chk("stall_valid", vec_t'(o_valid), vec_t'(1'b1));
                chk("stall_data", vec_t'({o_word_idx, o_curr_data, o_prev_data}), held);
            end
            if (o_bram_rd_en) begin
                chk("addr_a", vec_t'(o_bram_rd_addr_a), vec_t'({cur_a, rd_idx}));
                chk("addr_b", vec_t'(o_bram_rd_addr_b), vec_t'({cur_b, rd_idx}));
                rd_idx++;
                rd_pulses++;
            end
            last_fired = 1'b0;
            stalled    = 1'b0;
            if (o_valid) begin
                chk("last_flag", vec_t'(o_last), vec_t'(o_word_idx == 7'(WORDS - 1)));
                if (i_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_xfer", vec_t'(o_valid), vec_t'(1'b0));
                    end else begin
                        exp_e = sb.pop_front();
                        chk("xfer", vec_t'({o_word_idx, o_curr_data, o_prev_data}), exp_e);
                    end
                    xfers++;
                    last_fired = o_last;
                end else begin
                    stalled = 1'b1;
                    held    = vec_t'({o_word_idx, o_curr_data, o_prev_data});
                end
            end
        end
    end

    task automatic start_pass(input logic [1:0] c, input logic [1:0] p);
        @(posedge i_clk); #1;
        i_start          = 1'b1;
        i_curr_frame_loc = c;
        i_prev_frame_loc = p;
        cur_a            = c;
        cur_b            = p;
        rd_idx           = 7'd0;
        xfers            = 0;
        rd_pulses        = 0;
        for (int i = 0; i < WORDS; i++) begin
            sb.push_back(vec_t'({7'(i), pat({c, 7'(i)}, 1'b0), pat({p, 7'(i)}, 1'b1)}));
        end
        @(posedge i_clk); #1;
        i_start          = 1'b0;
        i_curr_frame_loc = ~c;
        i_prev_frame_loc = ~p;
    endtask

    task automatic finish_checks();
        chk("pass_count", vec_t'(xfers), vec_t'(WORDS));
        chk("sb_empty", vec_t'(sb.size()), vec_t'(0));
        @(posedge i_clk); #1;
        chk("idle_after", vec_t'({o_busy, o_valid}), vec_t'(2'b00));
    endtask

    task automatic wait_pass(input bit rnd_ready);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 3000) begin
            @(posedge i_clk); #1;
            n++;
            if (o_done) seen = 1'b1;
            if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
        end
        i_ready = 1'b1;
        chk("pass_done", vec_t'(seen), vec_t'(1'b1));
        finish_checks();
    endtask

    task automatic wait_xfers(input int target);
        int n = 0;
        while (xfers < target && n < 1000) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("reach_word", vec_t'(xfers >= target), vec_t'(1'b1));
    endtask

    task automatic quiesce_monitor();
        sb.delete();
        stalled    = 1'b0;
        last_fired = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog no completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        i_resetn         = 1'b0;
        i_start          = 1'b0;
        i_abort          = 1'b0;
        i_curr_frame_loc = 2'd0;
        i_prev_frame_loc = 2'd0;
        i_ready          = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_ctrl", vec_t'({o_valid, o_bram_rd_en, o_busy, o_done, o_last, o_start_err}), vec_t'(6'd0));
        chk("rst_addr", vec_t'({o_bram_rd_addr_a, o_bram_rd_addr_b}), vec_t'(18'd0));
        chk("rst_data", vec_t'({o_word_idx, o_curr_data, o_prev_data}), vec_t'(0));
        i_resetn = 1'b1;
        mon_en   = 1'b1;

        // Full pass with ready held high, including start-to-output latency.
        start_pass(2'd1, 2'd0);
        chk("n1_rd_en", vec_t'(o_bram_rd_en), vec_t'(1'b1));
        chk("n1_valid", vec_t'(o_valid), vec_t'(1'b0));
        chk("n1_busy", vec_t'(o_busy), vec_t'(1'b1));
        chk("n1_start_err", vec_t'(o_start_err), vec_t'(1'b0));
        n = 0;
        while (!o_done && n < 400) begin
            @(posedge i_clk); #1;
            n++;
            if (n == 1) chk("n2_valid", vec_t'(o_valid), vec_t'(1'b0));
            if (n == 2) chk("n3_valid", vec_t'(o_valid), vec_t'(1'b1));
        end
        chk("done_latency", vec_t'(n), vec_t'(130));
        finish_checks();

        // Pseudo-random back-pressure.
        start_pass(2'd2, 2'd3);
        wait_pass(1'b1);

        // Ready low for ten cycles after start: two reads then stall.
        i_ready = 1'b0;
        start_pass(2'd3, 2'd1);
        repeat (9) begin
            @(posedge i_clk); #1;
        end
        chk("stall_reads", vec_t'(rd_pulses), vec_t'(2));
        chk("stall_valid_hi", vec_t'(o_valid), vec_t'(1'b1));
        i_ready = 1'b1;
        p0 = rd_pulses;
        repeat (8) begin
            @(posedge i_clk); #1;
        end
        chk("resume_reads", vec_t'(rd_pulses - p0), vec_t'(8));
        wait_pass(1'b0);

        // Start while busy at word 40 is refused and the pass is unaffected.
        start_pass(2'd1, 2'd2);
        wait_xfers(40);
        i_start          = 1'b1;
        i_curr_frame_loc = 2'd0;
        i_prev_frame_loc = 2'd3;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        chk("start_err", vec_t'(o_start_err), vec_t'(1'b1));
        @(posedge i_clk); #1;
        chk("start_err_pulse", vec_t'(o_start_err), vec_t'(1'b0));
        wait_pass(1'b0);

        // Abort at word 60, then a clean pass.
        start_pass(2'd3, 2'd0);
        wait_xfers(60);
        i_abort = 1'b1;
        mon_en  = 1'b0;
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        chk("abort_ctrl", vec_t'({o_valid, o_busy, o_done, o_bram_rd_en}), vec_t'(4'd0));
        quiesce_monitor();
        mon_en = 1'b1;
        repeat (4) begin
            @(posedge i_clk); #1;
            chk("abort_quiet", vec_t'({o_valid, o_done}), vec_t'(2'b00));
        end
        start_pass(2'd0, 2'd1);
        wait_pass(1'b0);

        // One-cycle reset mid-pass, then a clean pass.
        start_pass(2'd2, 2'd1);
        wait_xfers(30);
        i_resetn = 1'b0;
        mon_en   = 1'b0;
        @(posedge i_clk); #1;
        chk("mrst_ctrl", vec_t'({o_valid, o_bram_rd_en, o_busy, o_done, o_last, o_start_err}), vec_t'(6'd0));
        chk("mrst_addr", vec_t'({o_bram_rd_addr_a, o_bram_rd_addr_b}), vec_t'(18'd0));
        chk("mrst_data", vec_t'({o_word_idx, o_curr_data, o_prev_data}), vec_t'(0));
        i_resetn = 1'b1;
        quiesce_monitor();
        mon_en = 1'b1;
        start_pass(2'd1, 2'd3);
        wait_pass(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
